// File: rtl/angle_frame_parser_pkg.sv
// Shared definitions for the angle-frame parser and its downstream consumers.
// Holds the header byte, frame geometry, FSM state encoding and the
// captured X-angle byte pair.
package angle_frame_parser_pkg;

  localparam logic [7:0]  HDR_BYTE    = 8'h55;
  localparam int unsigned FRAME_LEN   = 11;
  // Frame minus header, type and checksum bytes.
  localparam int unsigned PAYLOAD_LEN = FRAME_LEN - 3;
  localparam int unsigned IDX_W       = $clog2(PAYLOAD_LEN);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    TYPE    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  // X-angle byte pair as captured from payload indices 0 (xl) and 1 (xh).
  typedef struct packed {
    logic [7:0] xh;
    logic [7:0] xl;
  } lag_pair_t;

  // Modulo-256 checksum accumulation.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/angle_frame_parser_if.sv
// Byte-stream input and frame-result outputs of the angle-frame parser.
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   lag_xq/lag_xh    : held X-angle high/low byte from last good frame
//   frame_ok/err     : one-cycle result pulses
//   err_cnt          : saturating count of frame_err pulses
interface angle_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] lag_xq;
  logic [7:0] lag_xh;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  lag_xq, lag_xh, frame_ok, frame_err, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output lag_xq, lag_xh, frame_ok, frame_err, err_cnt
  );
endinterface

// File: rtl/angle_frame_parser_byte_timeout.sv
// Inter-byte idle counter. Clears on every byte, holds at zero while
// disabled, and flags expiry once TIMEOUT_CYC-1 idle cycles have elapsed.
//   clk, rst : clock, synchronous active-high reset
//   clear    : a byte arrived this cycle
//   enable   : a frame is in progress
//   expired  : abort request for this cycle (a concurrent byte suppresses it)
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 35000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count; parks at LAST so it cannot wrap before the FSM leaves.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/angle_frame_parser.sv
// Parses 11-byte angle frames (0x55, FRAME_TYPE, 8 payload bytes, SUM) from
// a byte stream, holds the X-angle bytes of the last good frame and reports
// per-frame result pulses plus a saturating error count.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of angle_frame_parser_if (byte in, results out)
module angle_frame_parser
  import angle_frame_parser_pkg::*;
#(
  parameter logic [7:0]  FRAME_TYPE  = 8'h53,
  parameter int unsigned TIMEOUT_CYC = 35000
) (
  input  logic                  clk,
  input  logic                  rst,
  angle_frame_parser_if.slave   bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  lag_pair_t        shadow_q, shadow_d;
  lag_pair_t        lag_q, lag_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic             expired;

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.rx_valid),
    .enable  (state_q != HUNT),
    .expired (expired)
  );

  // Next-state, checksum accumulation and result pulses.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    shadow_d = shadow_q;
    lag_d    = lag_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;

    if (bus.rx_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.rx_data == HDR_BYTE) state_d = TYPE;
        end
        TYPE: begin
          // A repeated header keeps us here so 55 55 53 still syncs.
          if (bus.rx_data == FRAME_TYPE) begin
            state_d = PAYLOAD;
            idx_d   = '0;
            sum_d   = sum8(HDR_BYTE, FRAME_TYPE);
          end else if (bus.rx_data != HDR_BYTE) begin
            state_d = HUNT;
          end
        end
        PAYLOAD: begin
          // Only XL/XH are retained; the other bytes just feed the sum.
          sum_d = sum8(sum_q, bus.rx_data);
          if (idx_q == IDX_W'(0)) shadow_d.xl = bus.rx_data;
          if (idx_q == IDX_W'(1)) shadow_d.xh = bus.rx_data;
          if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) state_d = CHECK;
          else                                  idx_d   = idx_q + IDX_W'(1);
        end
        CHECK: begin
          if (bus.rx_data == sum_q) begin
            lag_d = shadow_q;
            ok_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end else if (expired) begin
      state_d = HUNT;
      err_d   = 1'b1;
    end

    ecnt_d = (err_d && (ecnt_q != 8'hFF)) ? ecnt_q + 8'd1 : ecnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      sum_q    <= '0;
      shadow_q <= '0;
      lag_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      shadow_q <= shadow_d;
      lag_q    <= lag_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign bus.lag_xq    = lag_q.xh;
  assign bus.lag_xh    = lag_q.xl;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.err_cnt   = ecnt_q;

endmodule

// File: tb/tb_angle_frame_parser.sv
// Self-checking bench for angle_frame_parser: table of frames streamed
// back to back, plus hand sequences for timeout, reset and saturation.
module tb_angle_frame_parser;

  localparam int unsigned T  = 40;
  localparam logic [7:0]  FT = 8'h53;
  localparam logic [1:0]  K_NONE = 2'd0;
  localparam logic [1:0]  K_OK   = 2'b01;
  localparam logic [1:0]  K_ERR  = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  angle_frame_parser_if bus();

  angle_frame_parser #(.FRAME_TYPE(FT), .TIMEOUT_CYC(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] kind;
    logic [7:0] xq;
    logic [7:0] xh;
    logic [7:0] ecnt;
    int         cyc;
  } exp_t;

  typedef struct {
    int          n;
    logic [95:0] b;
    logic [1:0]  kind;
    logic [7:0]  xq;
    logic [7:0]  xh;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[8];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] m_xq   = 8'h00;
  logic [7:0] m_xh   = 8'h00;
  logic [7:0] m_ecnt = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [7:0] xq,
                          input logic [7:0] xh, input int lat);
    if (kind == K_ERR && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    if (kind == K_OK) begin
      m_xq = xq;
      m_xh = xh;
    end
    sb.push_back('{kind, xq, xh, m_ecnt, cyc + lat});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  // Full frame with given XL/XH and SUM; other payload bytes zero.
  task automatic send_frame(input logic [7:0] xl, input logic [7:0] xh,
                            input logic [7:0] sum, input logic [1:0] kind);
    send(8'h55); send(FT); send(xl); send(xh);
    repeat (6) send(8'h00);
    send(sum);
    if (kind == K_OK) push_exp(K_OK, xh, xl, 1);
    else              push_exp(K_ERR, m_xq, m_xh, 1);
  endtask

  // Scoreboard: every result pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (bus.frame_ok || bus.frame_err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: ok=%b err=%b with nothing expected (t=%0t)",
                 bus.frame_ok, bus.frame_err, $time);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {30'd0, bus.frame_err, bus.frame_ok}, {30'd0, e.kind});
        check("lag_xq", bus.lag_xq, e.xq);
        check("lag_xh", bus.lag_xh, e.xh);
        check("err_cnt", bus.err_cnt, e.ecnt);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vt[0] = '{11, 96'({8'h55, 8'h53, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE8}), K_OK,   8'h40, 8'h00};
    vt[1] = '{11, 96'({8'h55, 8'h53, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE9}), K_ERR,  8'h40, 8'h00};
    vt[2] = '{12, 96'({8'h55, 8'h55, 8'h53, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEE}), K_OK, 8'h34, 8'h12};
    vt[3] = '{11, 96'({8'h55, 8'h53, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h50}), K_OK,   8'h55, 8'h55};
    vt[4] = '{11, 96'({8'h55, 8'h53, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA0}), K_OK,   8'hFF, 8'hFF};
    vt[5] = '{12, 96'({8'h00, 8'h11, 8'h55, 8'h53, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hCC}), K_OK, 8'h02, 8'h01};
    vt[6] = '{11, 96'({8'h55, 8'h54, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09}), K_NONE, 8'h00, 8'h00};
    vt[7] = '{11, 96'({8'h55, 8'h53, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00}), K_ERR,  8'h02, 8'h01};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_lag_xq", bus.lag_xq, 8'h00);
    check("rst_lag_xh", bus.lag_xh, 8'h00);
    check("rst_frame_ok", bus.frame_ok, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_err_cnt", bus.err_cnt, 8'h00);
    rst = 1'b0;

    // Table frames, streamed with no gaps between bytes or frames.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vt[i].n; j++) begin
        send(vt[i].b[8*(vt[i].n-1-j) +: 8]);
        if (j == vt[i].n - 1 && vt[i].kind != K_NONE)
          push_exp(vt[i].kind, vt[i].xq, vt[i].xh, 1);
      end
    end
    idle(2);

    // Mid-frame stall: one abort exactly T cycles after the last byte.
    send(8'h55); send(FT); send(8'h01); send(8'h02); send(8'h03);
    push_exp(K_ERR, m_xq, m_xh, T + 1);
    idle(T + 10);
    send_frame(8'h21, 8'h43, 8'h0C, K_OK);
    idle(2);

    // Byte arriving on the would-be timeout cycle wins; frame completes.
    send(8'h55); send(FT);
    idle(T - 1);
    send(8'h5A); send(8'h0F);
    repeat (6) send(8'h00);
    send(8'h11);
    push_exp(K_OK, 8'h0F, 8'h5A, 1);
    // Long idle in HUNT must not abort.
    idle(3 * T);

    // Reset after byte 6 discards the partial frame silently.
    send(8'h55); send(FT); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_lag_xq", bus.lag_xq, 8'h00);
    check("midrst_lag_xh", bus.lag_xh, 8'h00);
    check("midrst_frame_ok", bus.frame_ok, 1'b0);
    check("midrst_frame_err", bus.frame_err, 1'b0);
    check("midrst_err_cnt", bus.err_cnt, 8'h00);
    m_xq = 8'h00; m_xh = 8'h00; m_ecnt = 8'h00;
    rst = 1'b0;
    idle(T + 5);
    send_frame(8'h00, 8'h40, 8'hE8, K_OK);
    idle(2);

    // Error counter saturation.
    for (int k = 0; k < 300; k++) send_frame(8'h00, 8'h40, 8'hE9, K_ERR);
    idle(3);
    check("err_cnt_saturated", bus.err_cnt, 8'hFF);
    check("lag_xq_after_bad", bus.lag_xq, 8'h40);

    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
